booth_mult_seq: RTL

Parametrised, iterative radix-4 Booth multiplier for the FFT datapath and the feature-extraction datapath. It latches two operands on a start handshake. It then retires one Booth digit (multiplier bit triple) per clock into an internal accumulator. It delivers the full-width product with a one-cycle done pulse. Signed (two's-complement) or unsigned operation is selected per operation, and an abort input cancels a running operation.

---
 rtl/booth_mult_seq.sv | 114 +++++++++++
 1 files changed

// File: rtl/booth_mult_seq.sv
// Iterative radix-4 Booth multiplier, one Booth digit retired per clock.
// Signed/unsigned per operation, with abort and a one-cycle done pulse.
module booth_mult_seq #(
    parameter int A_W    = 12,
    parameter int B_W    = 12,
    parameter int P_W    = A_W + B_W,
    parameter int N_STEP = (B_W + 2) / 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           is_signed,
    input  logic           abort,
    input  logic [A_W-1:0] mult_a,
    input  logic [B_W-1:0] mult_b,
    output logic           ready,
    output logic           busy,
    output logic           done,
    output logic [P_W-1:0] product
);

    localparam int BX_W  = 2 * N_STEP;
    localparam int CNT_W = $clog2(N_STEP);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_STEP - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [P_W-1:0]   a_q, a_d;
    logic [BX_W:0]    b_q, b_d;
    logic [P_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [P_W-1:0]   prod_q, prod_d;
    logic [P_W-1:0]   pp;
    logic [P_W-1:0]   sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
        end
    end

    // a_q advances by 2 bits per step, so the digit weight 4^i is implicit
    always_comb begin
        pp = '0;
        unique case (b_q[2:0])
            3'b001, 3'b010: pp = a_q;
            3'b011:         pp = a_q << 1;
            3'b100:         pp = -(a_q << 1);
            3'b101, 3'b110: pp = -a_q;
            default:        pp = '0;
        endcase
        sum = acc_q + pp;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d = {{(P_W-A_W){is_signed & mult_a[A_W-1]}}, mult_a};
                    b_d = {{(BX_W-B_W){is_signed & mult_b[B_W-1]}},
                           mult_b, 1'b0};
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    acc_d = sum;
                    a_d   = a_q << 2;
                    b_d   = b_q >> 2;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) begin
                        prod_d  = sum;
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign ready   = (state_q == IDLE);
    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign product = prod_q;

endmodule
